// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: stage indices, redirect source
// encoding and the forward-select width helper.
package pipe_ctrl_pkg;

  localparam int S_F = 0;
  localparam int S_D = 1;
  localparam int S_E = 2;

  typedef enum logic {
    REDIR_BRANCH = 1'b0,
    REDIR_TRAP   = 1'b1
  } redir_src_e;

  function automatic int fwd_width(input int nstage);
    return (nstage > 1) ? $clog2(nstage) : 1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_fwd.sv
// Forwarding select for one decode source: picks the youngest live producer in
// execute..commit whose destination matches, and reports whether it is a load.
module pipe_ctrl_fwd
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = 5,
  parameter int RW     = 5,
  parameter int FW     = 3
) (
  input  logic [NSTAGE-1:0]         valid_i,
  input  logic [NSTAGE-1:0]         wen_i,
  input  logic [NSTAGE-1:0]         load_i,
  input  logic [NSTAGE-1:0][RW-1:0] dst_i,
  input  logic [RW-1:0]             rs_i,
  input  logic                      use_i,
  output logic [FW-1:0]             sel_o,
  output logic                      load_o
);

  // Walk oldest to youngest so the youngest matching producer is the last write.
  always_comb begin
    sel_o  = '0;
    load_o = 1'b0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (k >= S_E && use_i && rs_i != '0 && valid_i[k] && wen_i[k] && dst_i[k] == rs_i) begin
        sel_o  = FW'(k);
        load_o = load_i[k];
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage valid/tag tracking, stall and flush generation,
// operand forwarding selects, a held fetch redirect, fetch epoch and instret.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int  NSTAGE = 5,
  parameter int  RW     = 5,
  parameter int  AW     = 64,
  parameter int  LDRDY  = NSTAGE - 1,
  parameter int  EW     = 2,
  localparam int FW     = fwd_width(NSTAGE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSTAGE-1:0] busy,
  input  logic              f_valid,
  input  logic [RW-1:0]     d_rs1,
  input  logic [RW-1:0]     d_rs2,
  input  logic              d_use1,
  input  logic              d_use2,
  input  logic [RW-1:0]     d_rd,
  input  logic              d_wen,
  input  logic              d_load,
  input  logic              br_valid,
  input  logic [AW-1:0]     br_pc,
  input  logic              trap_valid,
  input  logic [AW-1:0]     trap_pc,
  input  logic              redir_ready,
  output logic [NSTAGE-1:0] valid,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic [FW-1:0]     fwd1,
  output logic [FW-1:0]     fwd2,
  output logic              redir_valid,
  output logic [AW-1:0]     redir_pc,
  output logic [EW-1:0]     epoch,
  output logic [63:0]       instret
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] dst;
    logic          wen;
    logic          load;
  } stage_tag_t;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] pc;
  } redir_t;

  stage_tag_t [NSTAGE-1:0]   tag_q, tag_d;
  redir_t                    redir_q;
  redir_src_e                redir_src_q;
  logic [EW-1:0]             epoch_q;
  logic [63:0]               instret_q;

  logic [NSTAGE-1:0]         valid_v, wen_v, load_v;
  logic [NSTAGE-1:0][RW-1:0] dst_v;
  logic [FW-1:0]             sel1, sel2;
  logic                      ld1, ld2, load_use, trap_pending, retire;
  logic [NSTAGE-1:0]         stall_c, flush_c;

  always_comb begin
    valid_v = '0;
    wen_v   = '0;
    load_v  = '0;
    dst_v   = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      valid_v[i] = tag_q[i].valid;
      wen_v[i]   = tag_q[i].wen;
      load_v[i]  = tag_q[i].load;
      dst_v[i]   = tag_q[i].dst;
    end
  end

  pipe_ctrl_fwd #(.NSTAGE(NSTAGE), .RW(RW), .FW(FW)) u_fwd1 (
    .valid_i(valid_v), .wen_i(wen_v), .load_i(load_v), .dst_i(dst_v),
    .rs_i(d_rs1), .use_i(d_use1), .sel_o(sel1), .load_o(ld1)
  );

  pipe_ctrl_fwd #(.NSTAGE(NSTAGE), .RW(RW), .FW(FW)) u_fwd2 (
    .valid_i(valid_v), .wen_i(wen_v), .load_i(load_v), .dst_i(dst_v),
    .rs_i(d_rs2), .use_i(d_use2), .sel_o(sel2), .load_o(ld2)
  );

  assign load_use     = (ld1 && int'(sel1) < LDRDY) || (ld2 && int'(sel2) < LDRDY);
  assign trap_pending = redir_q.valid && (redir_src_q == REDIR_TRAP);
  assign retire       = valid_v[NSTAGE-1] && !busy[NSTAGE-1] && !trap_valid;

  // An empty stage never propagates back-pressure, so bubbles get squeezed out.
  always_comb begin
    flush_c = '0;
    if (trap_valid) flush_c[NSTAGE-2:0] = '1;
    else if (br_valid) flush_c[1:0] = '1;
    stall_c = '0;
    stall_c[NSTAGE-1] = busy[NSTAGE-1];
    for (int i = NSTAGE - 2; i >= 0; i--) begin
      stall_c[i] = busy[i] | (stall_c[i+1] & valid_v[i+1]);
    end
    if (load_use) begin
      stall_c[S_D] = 1'b1;
      stall_c[S_F] = 1'b1;
    end
    if (redir_q.valid) stall_c[S_F] = 1'b1;
  end

  always_comb begin
    tag_d = tag_q;
    tag_d[S_F].valid = ~flush_c[S_F];
    for (int i = 1; i < NSTAGE; i++) begin
      if (flush_c[i]) begin
        tag_d[i] = '0;
      end else if (!(stall_c[i] && valid_v[i])) begin
        if (i == S_D) begin
          tag_d[i]       = '0;
          tag_d[i].valid = f_valid & ~stall_c[S_F];
        end else if (i == S_E) begin
          tag_d[i].valid = valid_v[i-1] & ~stall_c[i-1] & ~flush_c[i-1];
          tag_d[i].dst   = d_rd;
          tag_d[i].wen   = d_wen;
          tag_d[i].load  = d_load;
        end else begin
          tag_d[i]       = tag_q[i-1];
          tag_d[i].valid = valid_v[i-1] & ~stall_c[i-1] & ~flush_c[i-1];
        end
      end
    end
  end

  // A trap always takes the redirect slot; a branch may not displace an unaccepted trap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q       <= '0;
      redir_q     <= '0;
      redir_src_q <= REDIR_BRANCH;
      epoch_q     <= '0;
      instret_q   <= '0;
    end else begin
      tag_q <= tag_d;
      if (trap_valid) begin
        redir_q     <= '{valid: 1'b1, pc: trap_pc};
        redir_src_q <= REDIR_TRAP;
      end else if (br_valid && !(trap_pending && !redir_ready)) begin
        redir_q     <= '{valid: 1'b1, pc: br_pc};
        redir_src_q <= REDIR_BRANCH;
      end else if (redir_q.valid && redir_ready) begin
        redir_q.valid <= 1'b0;
      end
      if (trap_valid || br_valid) epoch_q <= epoch_q + 1'b1;
      if (retire) instret_q <= instret_q + 64'd1;
    end
  end

  assign valid       = valid_v;
  assign stall       = reset ? '0 : (stall_c & ~flush_c);
  assign flush       = reset ? '0 : flush_c;
  assign fwd1        = reset ? '0 : sel1;
  assign fwd2        = reset ? '0 : sel2;
  assign redir_valid = redir_q.valid;
  assign redir_pc    = redir_q.pc;
  assign epoch       = epoch_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with fixed expectations, then randomized
// traffic checked every cycle against an instruction-movement model of the pipeline.
module tb_pipe_ctrl;

  localparam int NS  = 5;
  localparam int LDR = NS - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NS-1:0] busy;
  logic          f_valid, d_use1, d_use2, d_wen, d_load;
  logic [4:0]    d_rs1, d_rs2, d_rd;
  logic          br_valid, trap_valid, redir_ready;
  logic [63:0]   br_pc, trap_pc;
  logic [NS-1:0] valid, stall, flush;
  logic [2:0]    fwd1, fwd2;
  logic          redir_valid;
  logic [63:0]   redir_pc;
  logic [1:0]    epoch;
  logic [63:0]   instret;

  int n_cmp = 0;
  int n_err = 0;

  // Model: what each stage holds, plus redirect, epoch and retire count.
  bit          m_valid [NS];
  logic [4:0]  m_dst   [NS];
  bit          m_wen   [NS];
  bit          m_load  [NS];
  bit          m_rpend, m_rtrap;
  logic [63:0] m_rpc;
  int          m_epoch;
  logic [63:0] m_instret;
  logic [NS-1:0] e_block, e_stall, e_flush;
  logic [2:0]    e_fwd1, e_fwd2;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .busy(busy), .f_valid(f_valid),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use1(d_use1), .d_use2(d_use2),
    .d_rd(d_rd), .d_wen(d_wen), .d_load(d_load),
    .br_valid(br_valid), .br_pc(br_pc), .trap_valid(trap_valid), .trap_pc(trap_pc),
    .redir_ready(redir_ready), .valid(valid), .stall(stall), .flush(flush),
    .fwd1(fwd1), .fwd2(fwd2), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .epoch(epoch), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic int youngest_writer(input logic [4:0] rs);
    if (rs == 5'd0) return 0;
    for (int k = 2; k < NS; k++)
      if (m_valid[k] && m_wen[k] && m_dst[k] == rs) return k;
    return 0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_valid[s] = 0; m_dst[s] = '0; m_wen[s] = 0; m_load[s] = 0;
    end
    m_rpend = 0; m_rtrap = 0; m_rpc = '0; m_epoch = 0; m_instret = '0;
  endtask

  task automatic model_eval();
    int k1, k2;
    bit lu, blocked;
    k1 = d_use1 ? youngest_writer(d_rs1) : 0;
    k2 = d_use2 ? youngest_writer(d_rs2) : 0;
    lu = (k1 != 0 && m_load[k1] && k1 < LDR) || (k2 != 0 && m_load[k2] && k2 < LDR);
    e_fwd1 = 3'(k1);
    e_fwd2 = 3'(k2);
    e_flush = '0;
    if (trap_valid) begin
      for (int s = 0; s < NS - 1; s++) e_flush[s] = 1'b1;
    end else if (br_valid) begin
      e_flush[0] = 1'b1; e_flush[1] = 1'b1;
    end
    blocked = 0;
    for (int s = NS - 1; s >= 0; s--) begin
      if (s == NS - 1) blocked = busy[s];
      else blocked = busy[s] || (blocked && m_valid[s+1]);
      e_block[s] = blocked;
    end
    if (lu) begin e_block[0] = 1'b1; e_block[1] = 1'b1; end
    if (m_rpend) e_block[0] = 1'b1;
    e_stall = e_block & ~e_flush;
  endtask

  // Each live, unkilled instruction either stays (blocked) or moves one stage on.
  task automatic model_step();
    bit nv [NS]; logic [4:0] nd [NS]; bit nw [NS]; bit nl [NS];
    model_eval();
    for (int s = 0; s < NS; s++) begin nv[s] = 0; nd[s] = '0; nw[s] = 0; nl[s] = 0; end
    if (m_valid[NS-1] && !busy[NS-1] && !trap_valid) m_instret = m_instret + 64'd1;
    if (trap_valid) begin
      m_rpend = 1; m_rtrap = 1; m_rpc = trap_pc;
    end else if (br_valid && !(m_rpend && m_rtrap && !redir_ready)) begin
      m_rpend = 1; m_rtrap = 0; m_rpc = br_pc;
    end else if (redir_ready) begin
      m_rpend = 0;
    end
    if (trap_valid || br_valid) m_epoch = (m_epoch + 1) % 4;
    for (int s = 1; s < NS; s++) begin
      if (m_valid[s] && !e_flush[s]) begin
        if (e_block[s]) begin
          nv[s] = 1; nd[s] = m_dst[s]; nw[s] = m_wen[s]; nl[s] = m_load[s];
        end else if (s == 1) begin
          nv[2] = 1; nd[2] = d_rd; nw[2] = d_wen; nl[2] = d_load;
        end else if (s < NS - 1) begin
          nv[s+1] = 1; nd[s+1] = m_dst[s]; nw[s+1] = m_wen[s]; nl[s+1] = m_load[s];
        end
      end
    end
    if (f_valid && !e_block[0] && !e_flush[1]) nv[1] = 1;
    nv[0] = !e_flush[0];
    for (int s = 0; s < NS; s++) begin
      m_valid[s] = nv[s]; m_dst[s] = nd[s]; m_wen[s] = nw[s]; m_load[s] = nl[s];
    end
  endtask

  task automatic idle_inputs();
    busy = '0; f_valid = 1'b1; d_rs1 = '0; d_rs2 = '0; d_use1 = 0; d_use2 = 0;
    d_rd = '0; d_wen = 0; d_load = 0; br_valid = 0; br_pc = '0;
    trap_valid = 0; trap_pc = '0; redir_ready = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic fill(input int n);
    idle_inputs();
    repeat (n) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    busy = '1;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (valid !== 5'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %b expected 00000", valid); end
    n_cmp++; if (stall !== 5'b0) begin n_err++; $display("[TB] FAIL reset_stall: got %b expected 00000", stall); end
    n_cmp++; if (flush !== 5'b0) begin n_err++; $display("[TB] FAIL reset_flush: got %b expected 00000", flush); end
    n_cmp++; if (redir_valid !== 1'b0 || redir_pc !== 64'd0) begin n_err++; $display("[TB] FAIL reset_redir: got %b/%h expected 0/0", redir_valid, redir_pc); end
    n_cmp++; if (epoch !== 2'd0 || instret !== 64'd0) begin n_err++; $display("[TB] FAIL reset_counters: got epoch %0d instret %0d expected 0/0", epoch, instret); end
    do_reset();
  endtask

  task automatic test_forward();
    do_reset();
    fill(1);
    d_rd = 5'd5; d_wen = 1;
    tick();
    d_rd = 5'd6; d_rs1 = 5'd5; d_use1 = 1;
    @(negedge clk);
    n_cmp++; if (fwd1 !== 3'd2) begin n_err++; $display("[TB] FAIL fwd_alu_e: got %0d expected 2", fwd1); end
    n_cmp++; if (stall !== 5'b0) begin n_err++; $display("[TB] FAIL fwd_no_stall: got %b expected 00000", stall); end
    d_use1 = 0;
    #1;
    n_cmp++; if (fwd1 !== 3'd0) begin n_err++; $display("[TB] FAIL fwd_unused_src: got %0d expected 0", fwd1); end
    d_use1 = 1;
    tick();
    d_rd = 5'd0; d_rs1 = 5'd5; d_rs2 = 5'd6; d_use2 = 1;
    @(negedge clk);
    n_cmp++; if (fwd1 !== 3'd3 || fwd2 !== 3'd2) begin n_err++; $display("[TB] FAIL fwd_two_srcs: got %0d/%0d expected 3/2", fwd1, fwd2); end
    tick();
    d_wen = 0; d_rs1 = 5'd0; d_rs2 = 5'd5;
    @(negedge clk);
    n_cmp++; if (fwd1 !== 3'd0 || fwd2 !== 3'd4) begin n_err++; $display("[TB] FAIL fwd_x0_and_commit: got %0d/%0d expected 0/4", fwd1, fwd2); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    fill(1);
    d_rd = 5'd5; d_wen = 1; d_load = 1;
    tick();
    d_rd = 5'd6; d_load = 0; d_rs1 = 5'd5; d_use1 = 1;
    @(negedge clk);
    n_cmp++; if (stall !== 5'b00011 || fwd1 !== 3'd2) begin n_err++; $display("[TB] FAIL ldu_first: got stall %b fwd %0d expected 00011/2", stall, fwd1); end
    tick();
    @(negedge clk);
    n_cmp++; if (valid[2] !== 1'b0 || fwd1 !== 3'd3 || stall !== 5'b00011) begin n_err++; $display("[TB] FAIL ldu_bubble: got v2 %b fwd %0d stall %b expected 0/3/00011", valid[2], fwd1, stall); end
    tick();
    @(negedge clk);
    n_cmp++; if (fwd1 !== 3'd4 || stall !== 5'b0) begin n_err++; $display("[TB] FAIL ldu_release: got fwd %0d stall %b expected 4/00000", fwd1, stall); end
    tick();
  endtask

  task automatic test_busy();
    do_reset();
    fill(4);
    @(negedge clk);
    n_cmp++; if (valid !== 5'b11111) begin n_err++; $display("[TB] FAIL busy_full: got %b expected 11111", valid); end
    busy = 5'b01000;
    #1;
    n_cmp++; if (stall !== 5'b01111) begin n_err++; $display("[TB] FAIL busy_stall_c1: got %b expected 01111", stall); end
    tick();
    @(negedge clk);
    n_cmp++; if (stall !== 5'b01111 || valid !== 5'b01111) begin n_err++; $display("[TB] FAIL busy_stall_c2: got stall %b valid %b expected 01111/01111", stall, valid); end
    tick();
    busy = '0;
    @(negedge clk);
    // The commit-stage instruction retires on the first busy cycle; only the bubble follows.
    n_cmp++; if (instret !== 64'd1) begin n_err++; $display("[TB] FAIL busy_instret: got %0d expected 1", instret); end
  endtask

  task automatic test_branch();
    do_reset();
    fill(3);
    br_valid = 1; br_pc = 64'h8000_0040;
    @(negedge clk);
    n_cmp++; if (flush !== 5'b00011 || epoch !== 2'd0) begin n_err++; $display("[TB] FAIL br_flush: got %b epoch %0d expected 00011/0", flush, epoch); end
    tick();
    br_valid = 0;
    @(negedge clk);
    n_cmp++; if (redir_valid !== 1'b1 || redir_pc !== 64'h8000_0040 || epoch !== 2'd1) begin n_err++; $display("[TB] FAIL br_redir: got %b %h epoch %0d expected 1 80000040 1", redir_valid, redir_pc, epoch); end
    n_cmp++; if (stall[0] !== 1'b1 || valid[1:0] !== 2'b00) begin n_err++; $display("[TB] FAIL br_fetch_hold: got stall0 %b valid %b expected 1/xxx00", stall[0], valid); end
    tick();
    redir_ready = 1;
    @(negedge clk);
    n_cmp++; if (redir_valid !== 1'b1 || redir_pc !== 64'h8000_0040) begin n_err++; $display("[TB] FAIL br_held: got %b %h expected 1 80000040", redir_valid, redir_pc); end
    tick();
    redir_ready = 0;
    @(negedge clk);
    n_cmp++; if (redir_valid !== 1'b0 || epoch !== 2'd1) begin n_err++; $display("[TB] FAIL br_accept: got %b epoch %0d expected 0/1", redir_valid, epoch); end
  endtask

  task automatic test_trap_branch();
    do_reset();
    fill(4);
    trap_valid = 1; trap_pc = 64'h8000_0100; br_valid = 1; br_pc = 64'h8000_0040;
    @(negedge clk);
    n_cmp++; if (flush !== 5'b01111) begin n_err++; $display("[TB] FAIL trap_flush: got %b expected 01111", flush); end
    tick();
    trap_valid = 0; br_valid = 0;
    @(negedge clk);
    n_cmp++; if (redir_pc !== 64'h8000_0100 || epoch !== 2'd1) begin n_err++; $display("[TB] FAIL trap_wins: got %h epoch %0d expected 80000100/1", redir_pc, epoch); end
    br_valid = 1; br_pc = 64'h8000_0200;
    tick();
    br_valid = 0;
    @(negedge clk);
    n_cmp++; if (redir_pc !== 64'h8000_0100 || epoch !== 2'd2) begin n_err++; $display("[TB] FAIL trap_kept: got %h epoch %0d expected 80000100/2", redir_pc, epoch); end
    br_valid = 1; br_pc = 64'h8000_0300; redir_ready = 1;
    tick();
    br_valid = 0; redir_ready = 0;
    @(negedge clk);
    n_cmp++; if (redir_valid !== 1'b1 || redir_pc !== 64'h8000_0300 || epoch !== 2'd3) begin n_err++; $display("[TB] FAIL accept_and_new: got %b %h epoch %0d expected 1 80000300 3", redir_valid, redir_pc, epoch); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill(6);
    br_valid = 1; br_pc = 64'h8000_0500;
    tick();
    br_valid = 0;
    n_cmp++; if (instret !== 64'd3 || redir_valid !== 1'b1) begin n_err++; $display("[TB] FAIL pre_reset: got instret %0d redir %b expected 3/1", instret, redir_valid); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (redir_valid !== 1'b0 || valid !== 5'b0 || instret !== 64'd0 || epoch !== 2'd0) begin n_err++; $display("[TB] FAIL async_reset: got redir %b valid %b instret %0d epoch %0d expected 0/00000/0/0", redir_valid, valid, instret, epoch); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int s = 0; s < NS; s++) busy[s] = ($urandom_range(0, 7) == 0);
      f_valid = ($urandom_range(0, 4) != 0);
      d_rs1 = 5'($urandom_range(0, 7)); d_rs2 = 5'($urandom_range(0, 7));
      d_use1 = $urandom_range(0, 3) != 0; d_use2 = $urandom_range(0, 1) != 0;
      d_rd = 5'($urandom_range(0, 7)); d_wen = $urandom_range(0, 3) != 0;
      d_load = $urandom_range(0, 2) == 0;
      br_valid = ($urandom_range(0, 11) == 0); br_pc = {$urandom, $urandom};
      trap_valid = ($urandom_range(0, 24) == 0); trap_pc = {$urandom, $urandom};
      redir_ready = $urandom_range(0, 1) != 0;
      @(negedge clk);
      model_eval();
      n_cmp++; if (stall !== e_stall) begin n_err++; $display("[TB] FAIL rnd_stall c%0d: got %b expected %b", c, stall, e_stall); end
      n_cmp++; if (flush !== e_flush) begin n_err++; $display("[TB] FAIL rnd_flush c%0d: got %b expected %b", c, flush, e_flush); end
      n_cmp++; if (fwd1 !== e_fwd1 || fwd2 !== e_fwd2) begin n_err++; $display("[TB] FAIL rnd_fwd c%0d: got %0d/%0d expected %0d/%0d", c, fwd1, fwd2, e_fwd1, e_fwd2); end
      for (int s = 0; s < NS; s++) begin
        n_cmp++; if (valid[s] !== m_valid[s]) begin n_err++; $display("[TB] FAIL rnd_valid c%0d s%0d: got %b expected %b", c, s, valid[s], m_valid[s]); end
      end
      n_cmp++; if (redir_valid !== m_rpend || (m_rpend && redir_pc !== m_rpc)) begin n_err++; $display("[TB] FAIL rnd_redir c%0d: got %b %h expected %b %h", c, redir_valid, redir_pc, m_rpend, m_rpc); end
      n_cmp++; if (epoch !== 2'(m_epoch) || instret !== m_instret) begin n_err++; $display("[TB] FAIL rnd_counters c%0d: got %0d/%0d expected %0d/%0d", c, epoch, instret, m_epoch, m_instret); end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_busy();
    test_branch();
    test_trap_branch();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
